// File: rtl/multi_op_seq.sv
// rtl/multi_op_seq.sv - streaming operand/result sequencer with dot-product accumulation around multi_op
module multi_op_seq #(
    parameter int N     = 64,
    parameter int M     = 64,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [M-1:0]       in_b,
    input  logic [1:0]         in_op,
    input  logic               in_first,
    input  logic               in_last,
    output logic [N-1:0]       mo_a,
    output logic [M-1:0]       mo_b,
    output logic [N+M+1:0]     mo_c,
    output logic               mo_s0,
    output logic               mo_s1,
    input  logic [N+M+1:0]     mo_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N+M+1:0]     result,
    output logic [CNT_W-1:0]   beats
);
    localparam int W = N + M + 2;

    // State encodes {op_v, out_valid} directly.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_FULL  = 2'b01,
        S_BUSY  = 2'b10,
        S_BOTH  = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic             op_v;
    logic [N-1:0]     a_r;
    logic [M-1:0]     b_r;
    logic [1:0]       op_r;
    logic             first_r, last_r;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] acc_cnt;

    logic             is_mac, emit, stall, accept, retire;
    logic             op_v_nxt, ov_nxt;
    logic [CNT_W-1:0] base, cnt_inc;

    assign op_v      = state[1];
    assign out_valid = state[0];

    assign is_mac   = (op_r == 2'b11);
    assign emit     = op_v & (~is_mac | last_r);
    assign stall    = emit & out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign retire   = op_v & ~stall;

    assign base    = first_r ? '0 : acc_cnt;
    assign cnt_inc = (base == {CNT_W{1'b1}}) ? base : base + CNT_W'(1);

    assign mo_a  = a_r;
    assign mo_b  = b_r;
    assign mo_s0 = op_r[0];
    assign mo_s1 = op_r[1];
    assign mo_c  = (is_mac & ~first_r) ? acc : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        op_v_nxt = accept | stall;
        ov_nxt   = out_valid & ~out_ready;
        if (retire & emit) ov_nxt = 1'b1;
        state_nxt = state_t'({op_v_nxt, ov_nxt});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            acc     <= '0;
            acc_cnt <= '0;
            result  <= '0;
            beats   <= '0;
        end else begin
            if (accept) begin
                a_r     <= in_a;
                b_r     <= in_b;
                op_r    <= in_op;
                first_r <= in_first;
                last_r  <= in_last;
            end
            // Non-MAC beats leave the running sum alone so they can interleave.
            if (retire && is_mac) begin
                if (last_r) begin
                    acc     <= '0;
                    acc_cnt <= '0;
                end else begin
                    acc     <= mo_y;
                    acc_cnt <= cnt_inc;
                end
            end
            if (retire && emit) begin
                result <= mo_y;
                beats  <= is_mac ? cnt_inc : CNT_W'(1);
            end
        end
    end
endmodule
